// File: rtl/pipe_flow_ctrl.sv
// Stall/flush/exception sequencer for the five-stage Kabeta pipeline: drives the PC mux and the
// stage instruction-register controls, synchronises IrqReq and enforces the post-exception shadow.
module pipe_flow_ctrl #(
    parameter int SHADOW_CYCLES = 2,
    parameter int SYNC_STAGES   = 2
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       IrqReq,
    input  logic       IllOpRf,
    input  logic       LoadUseHazard,
    input  logic       BranchTakenRf,
    input  logic       MemBusy,
    input  logic       SupervisorRf,
    output logic       PcEnable,
    output logic [2:0] PcSel,
    output logic [3:0] IrEnable,
    output logic [3:0] IrFlush,
    output logic [3:0] IrExcAck,
    output logic       IrqAck
);

    typedef enum logic [1:0] {
        ST_RST    = 2'd0,
        ST_RUN    = 2'd1,
        ST_SHADOW = 2'd2
    } state_t;

    localparam logic [2:0] PCSEL_NEXT   = 3'd0;
    localparam logic [2:0] PCSEL_BRANCH = 3'd1;
    localparam logic [2:0] PCSEL_ILLOP  = 3'd2;
    localparam logic [2:0] PCSEL_XADDR  = 3'd3;
    localparam logic [2:0] PCSEL_RESET  = 3'd4;
    localparam logic [2:0] SHADOW_INIT  = 3'(SHADOW_CYCLES);

    state_t                 state_reg, state_next;
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   irq_pending_reg, irq_pending_next;
    logic [2:0]             shadow_cnt_reg, shadow_cnt_next;

    logic irq_sync;
    logic frozen;
    logic irq_take;
    logic exc_take;

    assign irq_sync = sync_reg[SYNC_STAGES-1];
    // MemBusy freezes everything, including the interrupt latch, outside the reset cycle.
    assign frozen   = (state_reg != ST_RST) && MemBusy;
    assign irq_take = (state_reg == ST_RUN) && !MemBusy && !IllOpRf && !SupervisorRf
                      && irq_pending_reg;
    assign exc_take = (state_reg == ST_RUN) && !MemBusy && (IllOpRf || irq_take);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_reg       <= ST_RST;
            sync_reg        <= '0;
            irq_pending_reg <= 1'b0;
            shadow_cnt_reg  <= 3'd0;
        end else begin
            state_reg       <= state_next;
            sync_reg        <= {sync_reg[SYNC_STAGES-2:0], IrqReq};
            irq_pending_reg <= irq_pending_next;
            shadow_cnt_reg  <= shadow_cnt_next;
        end
    end

    always_comb begin
        if (irq_take)
            irq_pending_next = 1'b0;
        else if (frozen)
            irq_pending_next = irq_pending_reg;
        else
            irq_pending_next = irq_pending_reg | irq_sync;
    end

    always_comb begin
        state_next      = state_reg;
        shadow_cnt_next = shadow_cnt_reg;
        PcEnable        = 1'b0;
        PcSel           = PCSEL_NEXT;
        IrEnable        = 4'b0000;
        IrFlush         = 4'b0000;
        IrExcAck        = 4'b0000;
        IrqAck          = 1'b0;

        case (state_reg)
            ST_RST: begin
                PcEnable   = 1'b1;
                PcSel      = PCSEL_RESET;
                IrEnable   = 4'b1111;
                IrFlush    = 4'b1111;
                state_next = ST_RUN;
            end
            ST_RUN, ST_SHADOW: begin
                if (MemBusy) begin
                    // full freeze: every output stays low and no state moves
                end else if (exc_take) begin
                    // RF gets a NOP, ALU gets the BNE that saves the return address in XP
                    PcEnable        = 1'b1;
                    PcSel           = IllOpRf ? PCSEL_ILLOP : PCSEL_XADDR;
                    IrEnable        = 4'b1111;
                    IrFlush         = 4'b0011;
                    IrExcAck        = 4'b0010;
                    IrqAck          = irq_take;
                    shadow_cnt_next = SHADOW_INIT;
                    state_next      = ST_SHADOW;
                end else if (LoadUseHazard) begin
                    IrEnable = 4'b1110;
                    IrFlush  = 4'b0010;
                end else if (BranchTakenRf) begin
                    PcEnable = 1'b1;
                    PcSel    = PCSEL_BRANCH;
                    IrEnable = 4'b1111;
                    IrFlush  = 4'b0001;
                end else begin
                    PcEnable = 1'b1;
                    IrEnable = 4'b1111;
                end

                if (state_reg == ST_SHADOW && !MemBusy) begin
                    shadow_cnt_next = shadow_cnt_reg - 3'd1;
                    if (shadow_cnt_reg <= 3'd1) begin
                        shadow_cnt_next = 3'd0;
                        state_next      = ST_RUN;
                    end
                end
            end
            default: begin
                state_next = ST_RST;
            end
        endcase

        if (!Reset) begin
            PcEnable = 1'b0;
            PcSel    = 3'd0;
            IrEnable = 4'b0000;
            IrFlush  = 4'b0000;
            IrExcAck = 4'b0000;
            IrqAck   = 1'b0;
        end
    end

endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// Directed bench for pipe_flow_ctrl: a vector table for the single-cycle rules and shadow
// timing, plus hand sequences for interrupt latency, supervisor masking and mid-shadow reset.
module tb_pipe_flow_ctrl;

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic       IrqReq = 1'b0, IllOpRf = 1'b0, LoadUseHazard = 1'b0;
    logic       BranchTakenRf = 1'b0, MemBusy = 1'b0, SupervisorRf = 1'b0;
    logic       PcEnable;
    logic [2:0] PcSel;
    logic [3:0] IrEnable, IrFlush, IrExcAck;
    logic       IrqAck;

    int checks = 0;
    int errors = 0;

    pipe_flow_ctrl #(.SHADOW_CYCLES(2), .SYNC_STAGES(2)) dut (
        .Clock(Clock), .Reset(Reset), .IrqReq(IrqReq), .IllOpRf(IllOpRf),
        .LoadUseHazard(LoadUseHazard), .BranchTakenRf(BranchTakenRf), .MemBusy(MemBusy),
        .SupervisorRf(SupervisorRf), .PcEnable(PcEnable), .PcSel(PcSel), .IrEnable(IrEnable),
        .IrFlush(IrFlush), .IrExcAck(IrExcAck), .IrqAck(IrqAck)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        string      nm;
        logic       ill, lu, br, mb;
        logic       pe;
        logic [2:0] sel;
        logic [3:0] en, fl, ea;
        logic       ack;
    } vec_t;

    vec_t tbl [23];

    // PcSel is only meaningful when the PC loads, unless the caller asks for it explicitly.
    task automatic chk(input string nm, input logic pe, input logic [2:0] sel,
                       input logic [3:0] en, input logic [3:0] fl, input logic [3:0] ea,
                       input logic ack, input logic force_sel);
        logic bad;
        checks++;
        bad = (PcEnable !== pe) || (IrEnable !== en) || (IrFlush !== fl) ||
              (IrExcAck !== ea) || (IrqAck !== ack) ||
              ((pe || force_sel) && (PcSel !== sel));
        if (bad) begin
            errors++;
            $display("FAIL %s: got pe=%b sel=%0d en=%b fl=%b ea=%b ack=%b, want pe=%b sel=%0d en=%b fl=%b ea=%b ack=%b",
                     nm, PcEnable, PcSel, IrEnable, IrFlush, IrExcAck, IrqAck,
                     pe, sel, en, fl, ea, ack);
        end
    endtask

    task automatic next_cycle();
        @(posedge Clock);
        #1;
    endtask

    task automatic idle_inputs();
        IllOpRf = 0; LoadUseHazard = 0; BranchTakenRf = 0; MemBusy = 0;
    endtask

    initial begin
        //             name          ill lu br mb  pe sel en       fl       ea       ack
        tbl[0]  = '{"rst_cycle",     0, 0, 0, 0,  1, 4, 4'b1111, 4'b1111, 4'b0000, 0};
        tbl[1]  = '{"run_idle",      0, 0, 0, 0,  1, 0, 4'b1111, 4'b0000, 4'b0000, 0};
        tbl[2]  = '{"illop_take",    1, 0, 0, 0,  1, 2, 4'b1111, 4'b0011, 4'b0010, 0};
        tbl[3]  = '{"shadow_ill1",   1, 0, 0, 0,  1, 0, 4'b1111, 4'b0000, 4'b0000, 0};
        tbl[4]  = '{"shadow_ill2",   1, 0, 0, 0,  1, 0, 4'b1111, 4'b0000, 4'b0000, 0};
        tbl[5]  = '{"illop_again",   1, 0, 0, 0,  1, 2, 4'b1111, 4'b0011, 4'b0010, 0};
        tbl[6]  = '{"shadow_idle1",  0, 0, 0, 0,  1, 0, 4'b1111, 4'b0000, 4'b0000, 0};
        tbl[7]  = '{"shadow_idle2",  0, 0, 0, 0,  1, 0, 4'b1111, 4'b0000, 4'b0000, 0};
        tbl[8]  = '{"lu_over_br",    0, 1, 1, 0,  0, 0, 4'b1110, 4'b0010, 4'b0000, 0};
        tbl[9]  = '{"branch",        0, 0, 1, 0,  1, 1, 4'b1111, 4'b0001, 4'b0000, 0};
        tbl[10] = '{"busy_ill1",     1, 0, 0, 1,  0, 0, 4'b0000, 4'b0000, 4'b0000, 0};
        tbl[11] = '{"busy_ill2",     1, 0, 0, 1,  0, 0, 4'b0000, 4'b0000, 4'b0000, 0};
        tbl[12] = '{"busy_ill3",     1, 0, 0, 1,  0, 0, 4'b0000, 4'b0000, 4'b0000, 0};
        tbl[13] = '{"ill_after_busy",1, 0, 0, 0,  1, 2, 4'b1111, 4'b0011, 4'b0010, 0};
        tbl[14] = '{"shadow_busy1",  0, 0, 0, 1,  0, 0, 4'b0000, 4'b0000, 4'b0000, 0};
        tbl[15] = '{"shadow_busy2",  0, 0, 0, 1,  0, 0, 4'b0000, 4'b0000, 4'b0000, 0};
        tbl[16] = '{"shadow_busy3",  0, 0, 0, 1,  0, 0, 4'b0000, 4'b0000, 4'b0000, 0};
        tbl[17] = '{"shadow_ext1",   1, 0, 0, 0,  1, 0, 4'b1111, 4'b0000, 4'b0000, 0};
        tbl[18] = '{"shadow_ext2",   1, 0, 0, 0,  1, 0, 4'b1111, 4'b0000, 4'b0000, 0};
        tbl[19] = '{"ill_post_ext",  1, 0, 0, 0,  1, 2, 4'b1111, 4'b0011, 4'b0010, 0};
        tbl[20] = '{"shadow_lu",     0, 1, 0, 0,  0, 0, 4'b1110, 4'b0010, 4'b0000, 0};
        tbl[21] = '{"shadow_br",     0, 0, 1, 0,  1, 1, 4'b1111, 4'b0001, 4'b0000, 0};
        tbl[22] = '{"run_after",     0, 0, 0, 0,  1, 0, 4'b1111, 4'b0000, 4'b0000, 0};

        // held in reset: everything low
        #2;
        chk("reset_low", 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 1);
        next_cycle();
        Reset = 1'b1;

        for (int i = 0; i < 23; i++) begin
            IllOpRf = tbl[i].ill; LoadUseHazard = tbl[i].lu;
            BranchTakenRf = tbl[i].br; MemBusy = tbl[i].mb;
            @(negedge Clock);
            $display("vec %0d %s pe=%b sel=%0d en=%b fl=%b ea=%b ack=%b",
                     i, tbl[i].nm, PcEnable, PcSel, IrEnable, IrFlush, IrExcAck, IrqAck);
            chk(tbl[i].nm, tbl[i].pe, tbl[i].sel, tbl[i].en, tbl[i].fl, tbl[i].ea, tbl[i].ack, 0);
            next_cycle();
        end
        idle_inputs();

        // interrupt latency: ack exactly SYNC_STAGES+1 edges after IrqReq rises
        IrqReq = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(negedge Clock);
            chk("irq_wait", 1, 0, 4'b1111, 4'b0000, 4'b0000, 0, 0);
            next_cycle();
        end
        @(negedge Clock);
        $display("irq ack=%b sel=%0d", IrqAck, PcSel);
        chk("irq_take", 1, 3, 4'b1111, 4'b0011, 4'b0010, 1, 0);
        IrqReq = 1'b0;
        SupervisorRf = 1'b1;
        next_cycle();

        // supervisor masks the re-latched level until it drops
        for (int n = 0; n < 8; n++) begin
            @(negedge Clock);
            chk("irq_masked", 1, 0, 4'b1111, 4'b0000, 4'b0000, 0, 0);
            next_cycle();
        end
        SupervisorRf = 1'b0;
        @(negedge Clock);
        $display("irq unmasked ack=%b sel=%0d", IrqAck, PcSel);
        chk("irq_unmask", 1, 3, 4'b1111, 4'b0011, 4'b0010, 1, 0);
        next_cycle();
        for (int n = 0; n < 4; n++) begin
            @(negedge Clock);
            chk("irq_quiet", 1, 0, 4'b1111, 4'b0000, 4'b0000, 0, 0);
            next_cycle();
        end

        // pending interrupt plus IllOpRf: illegal opcode wins, then reset mid-shadow
        IrqReq = 1'b1;
        SupervisorRf = 1'b1;
        for (int n = 0; n < 4; n++) next_cycle();
        SupervisorRf = 1'b0;
        IllOpRf = 1'b1;
        @(negedge Clock);
        chk("ill_beats_irq", 1, 2, 4'b1111, 4'b0011, 4'b0010, 0, 0);
        next_cycle();
        IllOpRf = 1'b0;
        BranchTakenRf = 1'b1;
        @(negedge Clock);
        chk("shadow_no_irq", 1, 1, 4'b1111, 4'b0001, 4'b0000, 0, 0);
        #1;
        Reset = 1'b0;
        #1;
        $display("reset mid-shadow pe=%b en=%b fl=%b", PcEnable, IrEnable, IrFlush);
        chk("reset_async", 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 1);
        IrqReq = 1'b0;
        BranchTakenRf = 1'b0;
        next_cycle();
        next_cycle();
        Reset = 1'b1;
        @(negedge Clock);
        chk("rst_again", 1, 4, 4'b1111, 4'b1111, 4'b0000, 0, 0);
        next_cycle();
        for (int n = 0; n < 5; n++) begin
            @(negedge Clock);
            chk("pending_clr", 1, 0, 4'b1111, 4'b0000, 4'b0000, 0, 0);
            next_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
